// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN inference pipeline.
//   CNN_N / CNN_Q        : default score word width and fractional bits
//   SCORE_MIN / SCORE_MAX: extreme signed values at the default width
//   state_t              : IDLE / COLLECT / DONE frame-collection states
//   saturate()           : clamp a signed value into a signed field of a
//                          given width (widths up to 31 bits), shared with
//                          the dense and MAC stages
package cnn_pkg;

  localparam int CNN_N = 16;
  localparam int CNN_Q = 8;

  localparam logic signed [CNN_N-1:0] SCORE_MIN = {1'b1, {(CNN_N-1){1'b0}}};
  localparam logic signed [CNN_N-1:0] SCORE_MAX = {1'b0, {(CNN_N-1){1'b1}}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Clamp value into [-(2^(width-1)), 2^(width-1)-1]. The caller truncates
  // the result to its own width.
  function automatic logic signed [31:0] saturate(input logic signed [31:0] value,
                                                  input int width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/argmax_update.sv
// One step of a running best / second-best search.
//   best, best_idx, second : current running state
//   score, idx             : candidate score and its class index
//   new_best, new_best_idx,
//   new_second             : state after considering the candidate
// A strictly greater score takes over the lead, so ties keep the lower
// index and the tied value drops into second.
module argmax_update
  import cnn_pkg::*;
#(
  parameter int N     = CNN_N,
  parameter int IDX_W = 4
) (
  input  logic signed [N-1:0]     best,
  input  logic        [IDX_W-1:0] best_idx,
  input  logic signed [N-1:0]     second,
  input  logic signed [N-1:0]     score,
  input  logic        [IDX_W-1:0] idx,
  output logic signed [N-1:0]     new_best,
  output logic        [IDX_W-1:0] new_best_idx,
  output logic signed [N-1:0]     new_second
);

  always_comb begin
    // NOTE: every output gets a default before the if-chain so no path
    // leaves one unassigned, which would infer a latch.
    new_best     = best;
    new_best_idx = best_idx;
    new_second   = second;
    if (score > best) begin
      new_second   = best;
      new_best     = score;
      new_best_idx = idx;
    end else if (score > second) begin
      new_second = score;
    end
  end

endmodule

// File: rtl/argmax_classifier.sv
// Final inference stage: collects NUM_CLASSES signed scores per frame and
// reports the winning class, its score and the margin over the runner-up.
//   clk, reset   : rising-edge clock, asynchronous active-high reset
//   start        : begin (or restart) a frame
//   in_valid     : score strobe, honoured only while in_ready is high
//   in_score     : signed score
//   in_ready     : high while collecting
//   busy         : high while collecting or reporting
//   class_idx    : index of the best score of the last completed frame
//   max_score    : that score
//   margin       : best minus second best, saturated, never negative
//   done         : one-cycle pulse when the three results update
module argmax_classifier
  import cnn_pkg::*;
#(
  parameter int N           = CNN_N,
  parameter int Q           = CNN_Q,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_W       = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic signed [N-1:0]  in_score,
  output logic                 in_ready,
  output logic                 busy,
  output logic [IDX_W-1:0]     class_idx,
  output logic signed [N-1:0]  max_score,
  output logic [N-1:0]         margin,
  output logic                 done
);

  // The saturate helper works in 32 bits, and the margin needs N+1 bits.
  if (N < 2 || N > 31 || Q < 0 || Q >= N || NUM_CLASSES < 1) begin : g_param_check
    $error("argmax_classifier: unsupported parameter combination");
  end

  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_CLASSES - 1);
  localparam logic signed [N-1:0] SCORE_LO = N'(saturate(32'sh8000_0000, N));

  state_t                  state;
  logic [IDX_W-1:0]        count;
  logic signed [N-1:0]     best;
  logic [IDX_W-1:0]        best_idx;
  logic signed [N-1:0]     second;

  logic signed [N-1:0]     upd_best;
  logic [IDX_W-1:0]        upd_best_idx;
  logic signed [N-1:0]     upd_second;
  logic signed [N:0]       diff;
  logic [N-1:0]            margin_next;

  argmax_update #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_update (
    .best         (best),
    .best_idx     (best_idx),
    .second       (second),
    .score        (in_score),
    .idx          (count),
    .new_best     (upd_best),
    .new_best_idx (upd_best_idx),
    .new_second   (upd_second)
  );

  // Results are taken from the updated pair so the last score counts in the
  // same edge that accepts it. best >= second always holds, so diff is never
  // negative and only the upper clamp can act (e.g. a single-class frame,
  // where second is still the minimum score).
  assign diff        = (N+1)'(upd_best) - (N+1)'(upd_second);
  assign margin_next = N'(saturate(32'(diff), N));

  assign in_ready = (state == ST_COLLECT);
  assign busy     = (state != ST_IDLE);

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      count     <= '0;
      best      <= SCORE_LO;
      best_idx  <= '0;
      second    <= SCORE_LO;
      class_idx <= '0;
      max_score <= '0;
      margin    <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        // Starts or aborts a frame from any state; a same-cycle score is
        // dropped and the published results are left alone.
        state    <= ST_COLLECT;
        count    <= '0;
        best     <= SCORE_LO;
        best_idx <= '0;
        second   <= SCORE_LO;
      end else begin
        case (state)
          ST_COLLECT: begin
            if (in_valid) begin
              best     <= upd_best;
              best_idx <= upd_best_idx;
              second   <= upd_second;
              if (count == LAST_IDX) begin
                // count is held here rather than stepped so it never wraps.
                state     <= ST_DONE;
                done      <= 1'b1;
                class_idx <= upd_best_idx;
                max_score <= upd_best;
                margin    <= margin_next;
              end else begin
                count <= count + IDX_W'(1);
              end
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/argmax_classifier.md
Name: argmax_classifier

Overview:
- Consumes the stream of per-class scores produced by the dense stage, one signed Q-format score per `in_valid` pulse (each driven from a dense `done` / `output_val` pair).
- After NUM_CLASSES scores, reports the winning class index, the winning score, and a confidence margin (best minus second best), with a one-cycle `done` pulse.
- Final stage of the inference pipeline; its results go to the top-level result register / LEDs.

Parameters:
- N, 16, score word width (signed fixed point).
- Q, 8, fractional bits. Informational only; the arithmetic is format-agnostic.
- NUM_CLASSES, 10, scores per frame (>=1).
- IDX_W, max(1,$clog2(NUM_CLASSES)), width of the class index.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begins a new frame (clears the running best/second).
- in_valid  in  1  score strobe; sampled only while `in_ready` = 1.
- in_score  in  N  signed score (dense `output_val`).
- in_ready  out  1  high while in COLLECT.
- busy  out  1  high in COLLECT and DONE.
- class_idx  out  IDX_W  index of the max score in the last completed frame.
- max_score  out  N  value of that score.
- margin  out  N  best minus second best, saturated, always >= 0.
- done  out  1  single-cycle pulse when the outputs update.

Behaviour:
- Reset (async, immediate):
  - state = IDLE; count = 0; best/second = SCORE_MIN (0x8000 for N=16).
  - Outputs: class_idx = 0, max_score = 0, margin = 0, done = 0, in_ready = 0, busy = 0.
- States:
  - IDLE to COLLECT on `start`.
  - COLLECT to DONE on the accepted score with count == NUM_CLASSES-1.
  - DONE to IDLE unconditionally, or to COLLECT if `start` is high.
- `start`:
  - In any state, clears count/best/best_idx/second and enters COLLECT next cycle.
  - `start` in COLLECT aborts the partial frame. No `done` is produced and the outputs keep their previous values.
  - `in_valid` in the same cycle as `start` is ignored.
- `in_valid` outside COLLECT is ignored; there is no backpressure beyond `in_ready`.
- Accept, in COLLECT with `in_valid` = 1:
  - If in_score > best (strict, signed): second <= best; best <= in_score; best_idx <= count.
  - Else if in_score > second: second <= in_score.
  - count <= count+1.
  - Ties keep the lower index; the tied value becomes second, giving margin 0.
- Completion: on the edge that accepts the last score, compute the final values from the updated best/second (combinational next-state) and register them.
  - class_idx, max_score, margin and done = 1 are all visible in the following cycle (state DONE).
  - Latency is one clock from the last `in_valid` to `done`.
  - `done` drops after exactly one cycle.
- Margin arithmetic: compute best - second in N+1 bits, then saturate to (2^(N-1))-1.
  - NUM_CLASSES = 1: second stays SCORE_MIN, so margin saturates to 0x7FFF.
- Outputs hold until the next completed frame; an abort does not disturb them.
- Back-to-back frames: `start` asserted in the DONE cycle is legal. The next frame's first score can be accepted the cycle after.
- Count never wraps; the comparison against NUM_CLASSES-1 ends the frame.
- Reset asserted mid-frame discards all state; the outputs return to their reset values.

Decomposition:
- Shared package cnn_pkg holds:
  - fixed-point N/Q defaults;
  - SCORE_MIN / SCORE_MAX constants;
  - the state enum (IDLE, COLLECT, DONE) typedef;
  - the saturate helper function shared with the dense/MAC stages.
- One natural sub-module: argmax_update, a combinational block. It takes (best, best_idx, second, score, idx) and returns the updated triple; it is reused later for top-k.

Test Plan:
- Distinct scores, NUM_CLASSES = 4: start, then 0x0100, 0x0380, 0xFF00, 0x0200 -> done 1 cycle after the 4th, class_idx = 1, max_score = 0x0380, margin = 0x0180.
- Tie: 0x0200, 0x0200, 0x0100, 0x0000 -> class_idx = 0, max_score = 0x0200, margin = 0.
- All negative / saturation: 0x8000, 0x7FFF, 0x8000, 0x8000 -> class_idx = 1, max_score = 0x7FFF, margin saturated 0x7FFF.
- Abort: start, 2 scores, start again, 4 scores (max 0x0050 at idx 2) -> exactly one done; class_idx = 2, max_score = 0x0050. Outputs unchanged before that done.
- Gaps and ignored strobes: in_valid pulses in IDLE and in the DONE cycle are ignored; scores spaced 3 cycles apart are still collected correctly. start in the DONE cycle starts the next frame with no lost scores.
- Reset mid-frame after 2 scores -> all outputs 0, in_ready = 0. A subsequent full frame produces correct results.
